// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master round-robin Wishbone arbiter, grant held per bus cycle
// Optional stalled-cycle watchdog enabled with WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_next;
  logic   last;
  logic   err_any;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GNT0 && state != GNT0) last <= 1'b0;
      else if (state_next == GNT1 && state != GNT1) last <= 1'b1;
    end
  end

  // Contention in IDLE goes to the master that was not granted last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_next = m0_cyc_i ? GNT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_pulse;

  assign timeout_pulse = (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts only uninterrupted stalled strobes of the current owner.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !s_stb_o || s_ack_i || s_err_i || timeout_pulse || state_next != state)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign err_any = s_err_i | timeout_pulse;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign err_any = s_err_i;
`endif

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & (state == GNT0);
  assign m1_ack_o = s_ack_i & (state == GNT1);
  assign m0_err_o = err_any & (state == GNT0);
  assign m1_err_o = err_any & (state == GNT1);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb/tb_wb_master_arbiter.sv - directed and randomized bench for wb_master_arbiter
// Honors WB_ARB_TIMEOUT_EN (watchdog limit 8 when defined).
module tb_wb_master_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err;

  always #5 clk = ~clk;

  wb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owner is -1 (nobody), 0 or 1; stall counts cycles of unanswered strobe.
  int owner = -1;
  int nxt;
  int stall = 0;
  bit last_m = 1'b1;
  bit c0, c1, stb_now;

  always @(posedge clk) begin
    if (rst) begin
      owner  = -1;
      last_m = 1'b1;
      stall  = 0;
    end else begin
      c0  = m0_cyc;
      c1  = m1_cyc;
      nxt = owner;
      if (owner == -1) begin
        if (c0 && c1) nxt = last_m ? 0 : 1;
        else if (c0)  nxt = 0;
        else if (c1)  nxt = 1;
      end else if (!(owner == 0 ? c0 : c1)) begin
        nxt = (owner == 0 ? c1 : c0) ? 1 - owner : -1;
      end
      if (TO_EN) begin
        stb_now = (owner == 0 && m0_stb) || (owner == 1 && m1_stb);
        if (nxt != owner || !stb_now || s_ack || s_err || stall == TO) stall = 0;
        else stall++;
      end
      if (nxt != owner && nxt >= 0) last_m = (nxt == 1);
      owner = nxt;
    end
  end

  logic [70:0] exp_s;
  logic [3:0]  exp_r;
  bit          pulse;

  always @(negedge clk) begin
    if (checking) begin
      if (owner == 0)      exp_s = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel};
      else if (owner == 1) exp_s = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel};
      else                 exp_s = '0;
      pulse = TO_EN && (stall == TO);
      exp_r = {s_ack && owner == 0, (s_err || pulse) && owner == 0,
               s_ack && owner == 1, (s_err || pulse) && owner == 1};
      chk("model_s_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}), 128'(exp_s));
      chk("model_ack_err", 128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 128'(exp_r));
      chk("model_rdata", 128'({m0_dat_o, m1_dat_o}), 128'({s_dat, s_dat}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  localparam logic [31:0] ADR_A = 32'h3000_0004;
  localparam logic [31:0] ADR_B = 32'h3000_0100;

  int pulses, first_pulse;

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_s_cyc", 128'(s_cyc_o), 128'(0));
    chk("reset_resp", 128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 128'(0));

    // Single request, slave acks two cycles after grant
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = ADR_A; m0_sel = 4'hF;
    tick();
    @(negedge clk);
    chk("single_adr", 128'(s_adr_o), 128'(ADR_A));
    chk("single_cyc", 128'(s_cyc_o), 128'(1));
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("single_ack", 128'({m0_ack_o, m1_ack_o}), 128'(2'b10));
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("single_release", 128'(s_cyc_o), 128'(0));

    // Contention from reset, zero-idle handover, then alternation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = ADR_B;
    tick();
    @(negedge clk);
    chk("contend_first", 128'(s_adr_o), 128'(ADR_A));
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("handover_adr", 128'(s_adr_o), 128'(ADR_B));
    chk("handover_cyc", 128'(s_cyc_o), 128'(1));
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    chk("alternate_m0", 128'(s_adr_o), 128'(ADR_A));
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Hold: m1 owns the bus for four transfers while m0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      @(negedge clk);
      chk("hold_ack", 128'({m0_ack_o, m1_ack_o}), 128'(2'b01));
      tick();
      s_ack = 1'b0;
      @(negedge clk);
      chk("hold_adr", 128'(s_adr_o), 128'(ADR_B));
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("hold_release", 128'(s_adr_o), 128'(ADR_A));
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // Read data to m1
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    s_dat = 32'hDEAD_BEEF; s_ack = 1'b1;
    @(negedge clk);
    chk("read_data", 128'(m1_dat_o), 128'(32'hDEAD_BEEF));
    chk("read_ack", 128'({m0_ack_o, m1_ack_o}), 128'(2'b01));
    tick();
    s_ack = 1'b0;

    // Mid-cycle reset during GNT1, then m0 wins contention
    rst = 1'b1;
    s_ack = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_cyc", 128'(s_cyc_o), 128'(0));
    chk("midreset_ack", 128'({m0_ack_o, m1_ack_o}), 128'(0));
    s_ack = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    @(negedge clk);
    chk("midreset_m0_wins", 128'(s_adr_o), 128'(ADR_A));
    clear_inputs();
    tick();

    // Stalled slave: watchdog pulse count and position
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = ADR_A;
    tick();
    pulses = 0;
    first_pulse = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m0_err_o) begin
        pulses++;
        if (first_pulse == 0) first_pulse = k;
      end
      tick();
    end
    chk("timeout_pulses", 128'(pulses), TO_EN ? 128'(1) : 128'(0));
    chk("timeout_cycle", 128'(first_pulse), TO_EN ? 128'(9) : 128'(0));
    clear_inputs();
    tick();

    // Randomized traffic against the reference
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = $urandom_range(0, 3) != 0;
      m1_stb = $urandom_range(0, 3) != 0;
      m0_we = $urandom_range(0, 1) == 1;
      m1_we = $urandom_range(0, 1) == 1;
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom);
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom);
      s_dat = $urandom;
      s_ack = $urandom_range(0, 5) == 0;
      s_err = $urandom_range(0, 15) == 0;
      tick();
    end
    clear_inputs();
    tick();
    @(negedge clk);
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
